// File: rtl/flist_ll.sv
// flist_ll: linked-list free-list manager for buffer/descriptor IDs.
// FIFO reissue order, simultaneous alloc+dealloc, double-free detection.
module flist_ll #(
  parameter int DEPTH = 256,
  parameter int ID_W  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            init_done,
  input  logic            alloc_req,
  output logic            alloc_ack,
  output logic [ID_W-1:0] alloc_id,
  input  logic            dealloc_req,
  input  logic [ID_W-1:0] dealloc_id,
  output logic            dealloc_ack,
  output logic            dealloc_err,
  output logic [ID_W:0]   free_count,
  output logic            empty
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [ID_W-1:0] id_t;
  typedef logic [ID_W:0]   cnt_t;
  typedef logic [IW-1:0]   ix_t;
  typedef enum logic {S_INIT, S_RUN} state_e;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam id_t  LAST    = id_t'(DEPTH - 1);

  state_e state_q, state_d;
  id_t    idx_q, idx_d;
  id_t    head_q, head_d;
  id_t    tail_q, tail_d;
  cnt_t   cnt_q, cnt_d;
  logic   err_q, err_d;

  id_t    next_q [DEPTH];
  logic   busy_q [DEPTH];

  logic   run, a_fire, d_req, d_rng, d_busy, d_ok;
  ix_t    h_ix, d_ix, nx_wa;
  id_t    nx_wd;
  logic   nx_we, bs_init;

  assign run  = (state_q == S_RUN);
  assign h_ix = head_q[IW-1:0];
  assign d_ix = dealloc_id[IW-1:0];

  assign init_done   = run;
  assign alloc_ack   = run & (cnt_q != '0);
  assign alloc_id    = head_q;
  assign dealloc_ack = run;
  assign dealloc_err = err_q;
  assign free_count  = cnt_q;
  assign empty       = (cnt_q == '0);

  // Dealloc is valid only for an in-range, allocated ID that is not the
  // head being handed out in this same cycle.
  assign a_fire = alloc_req & alloc_ack;
  assign d_req  = dealloc_req & run;
  assign d_rng  = ({1'b0, dealloc_id} < DEPTH_C);
  assign d_busy = d_rng & busy_q[d_ix];
  assign d_ok   = d_req & d_busy
                & ~(a_fire & (dealloc_id == head_q));
  assign err_d  = d_req & ~d_ok;

  // Next-state: init walk, then list head/tail/count updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    nx_we   = 1'b0;
    nx_wa   = tail_q[IW-1:0];
    nx_wd   = dealloc_id;
    bs_init = 1'b0;
    unique case (state_q)
      S_INIT: begin
        nx_we   = 1'b1;
        nx_wa   = idx_q[IW-1:0];
        nx_wd   = idx_q + id_t'(1);
        bs_init = 1'b1;
        idx_d   = idx_q + id_t'(1);
        if (idx_q == LAST) begin
          state_d = S_RUN;
          idx_d   = '0;
          head_d  = '0;
          tail_d  = LAST;
          cnt_d   = DEPTH_C;
        end
      end
      S_RUN: begin
        if (a_fire) begin
          if (d_ok && cnt_q == cnt_t'(1)) begin
            head_d = dealloc_id;
          end else begin
            head_d = next_q[h_ix];
          end
        end
        if (d_ok) begin
          tail_d = dealloc_id;
          if (cnt_q == '0) begin
            head_d = dealloc_id;
          end else begin
            nx_we = 1'b1;
          end
        end
        cnt_d = cnt_q + cnt_t'(d_ok) - cnt_t'(a_fire);
      end
      default: ;
    endcase
  end

  // Control registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      idx_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Pointer array and busy bitmap; rebuilt by the init walk.
  always_ff @(posedge clk) begin
    if (nx_we) next_q[nx_wa] <= nx_wd;
    if (bs_init) busy_q[idx_q[IW-1:0]] <= 1'b0;
    if (a_fire) busy_q[h_ix] <= 1'b1;
    if (d_ok) busy_q[d_ix] <= 1'b0;
  end

endmodule

// File: tb/tb_flist_ll.sv
// tb_flist_ll: scoreboard bench for flist_ll.
// Expected grants/errors queued by stimulus, checked by monitor.
module tb_flist_ll;

  localparam int DEPTH = 256;
  localparam int ID_W  = 9;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            init_done;
  logic            alloc_req;
  logic            alloc_ack;
  logic [ID_W-1:0] alloc_id;
  logic            dealloc_req;
  logic [ID_W-1:0] dealloc_id;
  logic            dealloc_ack;
  logic            dealloc_err;
  logic [ID_W:0]   free_count;
  logic            empty;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int err_exp = 0;

  flist_ll #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .init_done(init_done),
    .alloc_req(alloc_req),
    .alloc_ack(alloc_ack),
    .alloc_id(alloc_id),
    .dealloc_req(dealloc_req),
    .dealloc_id(dealloc_id),
    .dealloc_ack(dealloc_ack),
    .dealloc_err(dealloc_err),
    .free_count(free_count),
    .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_init_done"}, int'(init_done), 0);
    chk({nm, "_alloc_ack"}, int'(alloc_ack), 0);
    chk({nm, "_dealloc_ack"}, int'(dealloc_ack), 0);
    chk({nm, "_dealloc_err"}, int'(dealloc_err), 0);
    chk({nm, "_free_count"}, int'(free_count), 0);
    chk({nm, "_empty"}, int'(empty), 1);
    chk({nm, "_alloc_id"}, int'(alloc_id), 0);
  endtask

  // Release reset with junk requests held; count edges to init_done.
  task automatic do_init(input string nm);
    int n;
    n = 0;
    rst_n = 1'b1;
    alloc_req = 1'b1;
    dealloc_req = 1'b1;
    dealloc_id = 5;
    while (!init_done && n < 1000) begin
      tick();
      n++;
      if (n < DEPTH)
        chk({nm, "_early_dack"}, int'(dealloc_ack), 0);
    end
    alloc_req = 1'b0;
    dealloc_req = 1'b0;
    chk({nm, "_init_cycles"}, n, DEPTH);
    chk({nm, "_count"}, int'(free_count), DEPTH);
    chk({nm, "_empty"}, int'(empty), 0);
    chk({nm, "_alloc_id"}, int'(alloc_id), 0);
  endtask

  task automatic dealloc(input int id);
    dealloc_req = 1'b1;
    dealloc_id = ID_W'(id);
    tick();
    dealloc_req = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    alloc_req = 1'b1;
    repeat (n) tick();
    alloc_req = 1'b0;
  endtask

  // Monitor: grants and error pulses against the queued expectations.
  always @(negedge clk) begin
    if (alloc_req && alloc_ack) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL grant_unexpected: got %0d expected none",
                 alloc_id);
      end else begin
        chk("grant_id", int'(alloc_id), exp_q.pop_front());
      end
    end
    if (dealloc_err) begin
      tests++;
      if (err_exp == 0) begin
        fails++;
        $display("FAIL err_unexpected: got 1 expected 0");
      end else begin
        err_exp--;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    alloc_req = 1'b0;
    dealloc_req = 1'b0;
    dealloc_id = '0;
    #3;
    chk_reset("rst");
    tick();
    tick();
    do_init("init");

    for (int i = 0; i < DEPTH; i++) exp_q.push_back(i);
    alloc_req = 1'b1;
    repeat (DEPTH) tick();
    chk("drain_count", int'(free_count), 0);
    chk("drain_empty", int'(empty), 1);
    chk("drain_ack", int'(alloc_ack), 0);
    repeat (300 - DEPTH) tick();
    alloc_req = 1'b0;
    chk("drain_left", exp_q.size(), 0);

    dealloc(7);
    chk("d7_count", int'(free_count), 1);
    chk("d7_head", int'(alloc_id), 7);
    dealloc(3);
    chk("d3_count", int'(free_count), 2);
    dealloc(200);
    chk("d200_count", int'(free_count), 3);
    exp_q.push_back(7);
    exp_q.push_back(3);
    exp_q.push_back(200);
    alloc_n(3);
    chk("reissue_count", int'(free_count), 0);
    chk("reissue_left", exp_q.size(), 0);

    dealloc(5);
    exp_q.push_back(5);
    alloc_req = 1'b1;
    dealloc_req = 1'b1;
    dealloc_id = 9;
    tick();
    alloc_req = 1'b0;
    dealloc_req = 1'b0;
    chk("sim_head", int'(alloc_id), 9);
    chk("sim_count", int'(free_count), 1);
    exp_q.push_back(9);
    alloc_n(1);
    chk("sim_empty", int'(empty), 1);

    dealloc(10);
    chk("d10_count", int'(free_count), 1);
    err_exp++;
    chk("dbl_ack", int'(dealloc_ack), 1);
    dealloc(10);
    chk("dbl_count", int'(free_count), 1);
    chk("dbl_err", int'(dealloc_err), 1);
    tick();
    chk("dbl_err_clr", int'(dealloc_err), 0);
    err_exp++;
    dealloc(300);
    chk("oor_count", int'(free_count), 1);
    chk("oor_err", int'(dealloc_err), 1);
    tick();
    chk("oor_err_clr", int'(dealloc_err), 0);
    exp_q.push_back(10);
    err_exp++;
    alloc_req = 1'b1;
    dealloc_req = 1'b1;
    dealloc_id = 10;
    tick();
    alloc_req = 1'b0;
    dealloc_req = 1'b0;
    chk("headfree_count", int'(free_count), 0);
    chk("headfree_err", int'(dealloc_err), 1);
    tick();

    rst_n = 1'b0;
    tick();
    do_init("reinit1");
    for (int i = 0; i < 40; i++) exp_q.push_back(i);
    alloc_req = 1'b1;
    repeat (40) tick();
    chk("mid_count", int'(free_count), DEPTH - 40);
    alloc_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    tick();
    tick();
    do_init("reinit2");
    exp_q.push_back(0);
    alloc_n(1);
    chk("post_count", int'(free_count), DEPTH - 1);
    chk("post_head", int'(alloc_id), 1);
    tick();
    chk("final_queue", exp_q.size(), 0);
    chk("final_err", err_exp, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/flist_ll.md
# flist_ll

Parametrised linked-list free-list manager for buffer/descriptor IDs: hands out IDs on allocation and takes them back on deallocation, with single-cycle valid/ack handshakes on both ports. It generalises the fixed-width free list with a `DEPTH` parameter, simultaneous alloc+dealloc in one cycle, an occupancy count, and double-free/out-of-range detection. It sits between packet-buffer writers, which allocate, and readers, which deallocate, in the linked-list FIFO subsystem.

## Interface
- `DEPTH`, 256: number of managed IDs, range 2..2^`ID_W`.
- `ID_W`, 8: ID width. Must satisfy 2^`ID_W` >= `DEPTH`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low. Deassertion is synchronous to `clk` upstream.
- `init_done` out 1: high once the free list is built; stays high until the next reset.
- `alloc_req` in 1: requester wants an ID (level).
- `alloc_ack` out 1: an ID is available. The transfer happens in a cycle where `alloc_req` and `alloc_ack` are both high.
- `alloc_id` out `ID_W`: ID granted; valid whenever `alloc_ack`=1.
- `dealloc_req` in 1: requester returns `dealloc_id` (level).
- `dealloc_id` in `ID_W`: ID being returned.
- `dealloc_ack` out 1: equals `init_done`. The transfer happens in a cycle where `dealloc_req` and `dealloc_ack` are both high.
- `dealloc_err` out 1: one-cycle pulse, registered, the cycle after a rejected deallocation.
- `free_count` out `ID_W`+1: number of free IDs.
- `empty` out 1: `free_count`==0.

## Operation
- Storage:
  - `next[DEPTH]` pointer array, combinational read, synchronous write.
  - `head`, `tail` and `free_count` registers.
  - `busy[DEPTH]` bitmap, 1 = ID currently allocated.
- States:
  - INIT: index `i` runs 0..`DEPTH`-1, one per cycle, writing `next[i]`=`i`+1 and `busy[i]`=0. On `i`=`DEPTH`-1 the block sets `head`=0, `tail`=`DEPTH`-1, `free_count`=`DEPTH` and moves to RUN.
  - RUN: stays in RUN until reset.
- Handshakes:
  - `alloc_ack` = RUN & `free_count`!=0.
  - `alloc_id` = `head`.
  - Both ack outputs are driven from registers only; they have no combinational path from the req inputs.
- Alloc transfer: `head`<=`next[head]`, `busy[head]`<=1, `free_count`-1.
- Dealloc transfer, when valid:
  - Valid means `dealloc_id`<`DEPTH` and `busy[dealloc_id]`=1.
  - The block writes `next[tail]`<=`dealloc_id`, then `tail`<=`dealloc_id`, `busy`<=0, `free_count`+1.
  - If the list was empty (`free_count`=0), it sets `head`<=`dealloc_id` instead of writing `next`.
- Invalid dealloc (out of range or double free):
  - Still acked.
  - List, bitmap and count are unchanged.
  - `dealloc_err` pulses the next cycle.
- Simultaneous alloc+dealloc in the same cycle:
  - Both take effect and `free_count` is unchanged.
  - If `free_count`=1, `head`<=`dealloc_id` and `tail`<=`dealloc_id`; the `next[head]` read is bypassed.
  - If `dealloc_id`==`head`, the dealloc is a double free: it is rejected, and the alloc proceeds.
- Allocation order is FIFO: 0,1,2,… after init; freed IDs are reissued in the order they were returned.
- `free_count` never exceeds `DEPTH` and never underflows.

## Timing
- Reset values:
  - `init_done`=0, `alloc_ack`=0, `dealloc_ack`=0, `dealloc_err`=0.
  - `free_count`=0, `empty`=1, `alloc_id`=0.
  - State = INIT, `i`=0.
- Init:
  - The first rising edge after `rst_n` deasserts writes entry 0.
  - `init_done`=1 after exactly `DEPTH` edges (256 cycles at default).
- Allocation latency:
  - The transfer completes in the handshake cycle.
  - Updated `alloc_id`/`free_count` are visible the next cycle.
  - Back-to-back allocations at one per cycle are supported.
- Dealloc:
  - One per cycle.
  - A returned ID is allocatable the cycle after return; when the list was empty, it appears on `alloc_id` the cycle after.
- Reset mid-operation:
  - All state clears immediately, asynchronously.
  - Outstanding IDs are forgotten and init restarts.
- Requests presented before `init_done`: not acked, with no side effects.

## Test plan
- Reset, release, hold `alloc_req`=0 -> `init_done` rises after 256 cycles; `free_count`=256, `empty`=0, `alloc_id`=0.
- Hold `alloc_req`=1 for 300 cycles -> IDs 0..255 granted on consecutive cycles; then `alloc_ack`=0, `empty`=1, `free_count`=0, with no further grants.
- From empty, dealloc 7, then 3, then 200 -> `free_count` 1,2,3; the next three allocs return 7, 3, 200 in that order.
- With `free_count`=1 (head=5), alloc and dealloc ID 9 in the same cycle -> 5 granted; next cycle `alloc_id`=9, `free_count`=1.
- Dealloc an already-free ID 10, then ID 300 with `DEPTH`=256, `ID_W`=9 -> `dealloc_ack`=1, `dealloc_err` pulses one cycle each, `free_count` unchanged.
- Assert `rst_n`=0 mid-traffic with 40 IDs allocated -> outputs return to reset values immediately; after re-init, `free_count`=256 and the first grant is 0.
